mantissa_normalizer: RTL

MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

---
 rtl/mantissa_normalizer_if.sv | 28 ++
 rtl/mantissa_normalizer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mantissa_normalizer_if.sv
// Normalizer handshake bundle: input sum/exponent (valid/ready) and rounded result with flags (valid/ready).
// master drives the input side and out_ready; slave is the normalizer itself.
interface mantissa_normalizer_if #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_WIDTH      = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [MANTISSA_WIDTH+4:0] sum_m;
    logic [EXP_WIDTH-1:0]      exp_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [MANTISSA_WIDTH-1:0] m_out;
    logic [EXP_WIDTH-1:0]      e_out;
    logic                      zero;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output in_valid, sum_m, exp_in, out_ready,
        input  in_ready, out_valid, m_out, e_out, zero, overflow, underflow
    );

    modport slave (
        input  in_valid, sum_m, exp_in, out_ready,
        output in_ready, out_valid, m_out, e_out, zero, overflow, underflow
    );
endinterface

// File: rtl/mantissa_normalizer.sv
// Normalizes and RNE-rounds an adder sum; MANTISSA_NORMALIZER_LZC_EN selects one-cycle LZC shift (latency 3) over 1-bit/cycle shift.
// Latency s+2 (s = SHIFT cycles); one transaction in flight, result held in DONE until out_ready, in_ready only in IDLE.
module mantissa_normalizer #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mantissa_normalizer_if.slave  bus
);
    localparam int W  = MANTISSA_WIDTH;
    localparam int E  = EXP_WIDTH;
    localparam int SW = W + 5;
    localparam logic [E-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   mant_q, mant_d;
    logic [E-1:0]    exp_q, exp_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [W-1:0]    res_m_q, res_m_d;
    logic [E-1:0]    res_e_q, res_e_d;
    logic            res_zero_q, res_zero_d;
    logic            res_ovf_q, res_ovf_d;
    logic            res_unf_q, res_unf_d;
    logic            out_valid_q, out_valid_d;

    logic            rnd_inc;
    logic [W-1:0]    frac_rnd;
    logic [E-1:0]    exp_rnd;

    // Round-to-nearest-even on the normalized working mantissa: LSB at [3], G/R/S at [2:0].
    always_comb begin
        rnd_inc  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        frac_rnd = mant_q[SW-3:3];
        exp_rnd  = exp_q;
        if (rnd_inc) begin
            if (&mant_q[SW-3:3]) begin
                frac_rnd = '0;
                exp_rnd  = exp_q + E'(1);
            end else begin
                frac_rnd = mant_q[SW-3:3] + W'(1);
            end
        end
    end

`ifdef MANTISSA_NORMALIZER_LZC_EN
    localparam int CW = $clog2(SW);
    logic [CW-1:0] lz;

    // Distance of the highest set bit below the carry position from the leading-one slot.
    always_comb begin
        lz = '0;
        for (int i = 0; i < SW - 1; i++) begin
            if (mant_q[i]) lz = CW'(SW - 2 - i);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        res_m_d     = res_m_q;
        res_e_d     = res_e_q;
        res_zero_d  = res_zero_q;
        res_ovf_d   = res_ovf_q;
        res_unf_d   = res_unf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mant_d  = bus.sum_m;
                    exp_d   = bus.exp_in;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q[SW-1]) begin
                    mant_d  = {1'b0, mant_q[SW-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + E'(1);
                    ovf_d   = (exp_d == EXP_MAX);
                    state_d = ROUND;
                end else if (mant_q == '0) begin
                    zero_d  = 1'b1;
                    exp_d   = '0;
                    state_d = ROUND;
                end else if (mant_q[SW-2]) begin
                    state_d = ROUND;
                end else begin
`ifdef MANTISSA_NORMALIZER_LZC_EN
                    if (32'(lz) >= 32'(exp_q)) begin
                        unf_d  = 1'b1;
                        mant_d = '0;
                        exp_d  = '0;
                    end else begin
                        mant_d = mant_q << lz;
                        exp_d  = exp_q - E'(lz);
                    end
                    state_d = ROUND;
`else
                    if (exp_q > E'(1)) begin
                        mant_d = {mant_q[SW-2:0], 1'b0};
                        exp_d  = exp_q - E'(1);
                    end else begin
                        unf_d   = 1'b1;
                        mant_d  = '0;
                        exp_d   = '0;
                        state_d = ROUND;
                    end
`endif
                end
            end
            ROUND: begin
                res_zero_d = zero_q;
                res_unf_d  = unf_q;
                res_ovf_d  = 1'b0;
                res_m_d    = '0;
                res_e_d    = '0;
                if (!(zero_q || unf_q)) begin
                    if (ovf_q || exp_rnd == EXP_MAX) begin
                        res_ovf_d = 1'b1;
                        res_e_d   = EXP_MAX;
                    end else begin
                        res_m_d = frac_rnd;
                        res_e_d = exp_rnd;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                // Result regs load on entry; out_valid follows one cycle later.
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            res_m_q     <= '0;
            res_e_q     <= '0;
            res_zero_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_unf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            res_m_q     <= res_m_d;
            res_e_q     <= res_e_d;
            res_zero_q  <= res_zero_d;
            res_ovf_q   <= res_ovf_d;
            res_unf_q   <= res_unf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.m_out     = out_valid_q ? res_m_q : '0;
    assign bus.e_out     = out_valid_q ? res_e_q : '0;
    assign bus.zero      = out_valid_q & res_zero_q;
    assign bus.overflow  = out_valid_q & res_ovf_q;
    assign bus.underflow = out_valid_q & res_unf_q;

endmodule
